// File: rtl/sm_sort_pkg.sv
// Shared types for the sign-magnitude sort sequencer: FSM states and the
// bit positions inside the status word.
package sm_sort_pkg;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SORT   = 2'd1,
        UNLOAD = 2'd2
    } state_e;

    localparam int ST_SORTING = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_SWAP    = 2;
    localparam int ST_DUP     = 3;

endpackage

// File: rtl/sm_lt_cmp.sv
// Combinational sign-magnitude less-than: lt = (a < b), with -0 ordered
// below +0 and raw-identical words never less than each other.
module sm_lt_cmp #(
    parameter int M = 8
) (
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
    output logic         lt
);

    always_comb begin
        lt = 1'b0;
        if (a == b) begin
            lt = 1'b0;
        end else if (a[M-1] != b[M-1]) begin
            lt = a[M-1];
        end else if (!a[M-1]) begin
            lt = a[M-2:0] < b[M-2:0];
        end else begin
            // Both negative: the larger magnitude is the smaller value.
            lt = a[M-2:0] > b[M-2:0];
        end
    end

endmodule

// File: rtl/sm_sort_sequencer.sv
// Buffers a burst of sign-magnitude words, bubble-sorts it in place with one
// shared comparator (one compare per cycle, early exit), then streams it out.
module sm_sort_sequencer
    import sm_sort_pkg::*;
#(
    parameter int M     = 8,
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [M-1:0]               i_data,
    input  logic                       i_last,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [M-1:0]               o_data,
    output logic                       o_last,
    output logic [3:0]                 o_status,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    state_e        state_q;
    logic [CW-1:0] count_q;
    logic [CW-1:0] pass_q;
    logic [IW-1:0] j_q;
    logic [IW-1:0] rd_q;
    logic          passSwap_q;
    logic          swapSeen_q;
    logic          dupSeen_q;
    logic [M-1:0]  buf_q [DEPTH];

    logic [IW-1:0] jNext;
    logic [M-1:0]  cmpLo;
    logic [M-1:0]  cmpHi;
    logic          hiLtLo;
    logic          cmpEn;
    logic          swapNow;
    logic          dupNow;
    logic          passEnd;
    logic          lastPass;
    logic          accept;
    logic          loadDone;
    logic          unloadLast;
    logic          handshake;

    assign jNext = j_q + IW'(1);
    assign cmpLo = buf_q[j_q];
    assign cmpHi = buf_q[jNext];

    sm_lt_cmp #(
        .M (M)
    ) uCmp (
        .a  (cmpHi),
        .b  (cmpLo),
        .lt (hiLtLo)
    );

    // A single-word burst spends its one SORT cycle without comparing.
    assign cmpEn      = (state_q == SORT) && (count_q != CW'(1));
    assign swapNow    = cmpEn && hiLtLo;
    assign dupNow     = cmpEn && (cmpHi == cmpLo);
    assign passEnd    = CW'(j_q) == (count_q - CW'(2) - pass_q);
    assign lastPass   = pass_q == (count_q - CW'(2));
    assign accept     = (state_q == LOAD) && i_valid;
    assign loadDone   = accept && (i_last || (count_q == CW'(DEPTH - 1)));
    assign unloadLast = CW'(rd_q) == (count_q - CW'(1));
    assign handshake  = (state_q == UNLOAD) && i_ready;

    // Storage has no reset; the swap write-back lands on the compare cycle.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            buf_q[count_q[IW-1:0]] <= i_data;
        end else if (swapNow) begin
            buf_q[j_q]   <= cmpHi;
            buf_q[jNext] <= cmpLo;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= LOAD;
            count_q    <= '0;
            pass_q     <= '0;
            j_q        <= '0;
            rd_q       <= '0;
            passSwap_q <= 1'b0;
            swapSeen_q <= 1'b0;
            dupSeen_q  <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        count_q <= count_q + CW'(1);
                        if (count_q == '0) begin
                            swapSeen_q <= 1'b0;
                            dupSeen_q  <= 1'b0;
                        end
                        if (loadDone) begin
                            state_q    <= SORT;
                            j_q        <= '0;
                            pass_q     <= '0;
                            passSwap_q <= 1'b0;
                        end
                    end
                end
                SORT: begin
                    if (swapNow) swapSeen_q <= 1'b1;
                    if (dupNow)  dupSeen_q  <= 1'b1;
                    if (!cmpEn) begin
                        state_q <= UNLOAD;
                        rd_q    <= '0;
                    end else if (passEnd) begin
                        // A clean pass means sorted; the final pass is reached regardless.
                        if (!(passSwap_q || swapNow) || lastPass) begin
                            state_q <= UNLOAD;
                            rd_q    <= '0;
                        end else begin
                            pass_q     <= pass_q + CW'(1);
                            j_q        <= '0;
                            passSwap_q <= 1'b0;
                        end
                    end else begin
                        j_q        <= jNext;
                        passSwap_q <= passSwap_q || swapNow;
                    end
                end
                UNLOAD: begin
                    if (handshake) begin
                        if (unloadLast) begin
                            state_q <= LOAD;
                            count_q <= '0;
                        end else begin
                            rd_q <= rd_q + IW'(1);
                        end
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    always_comb begin
        o_status              = 4'b0000;
        o_status[ST_SORTING]  = (state_q == SORT);
        o_status[ST_DONE]     = (state_q == UNLOAD);
        o_status[ST_SWAP]     = swapSeen_q;
        o_status[ST_DUP]      = dupSeen_q;
    end

    assign o_ready = (state_q == LOAD);
    assign o_valid = (state_q == UNLOAD);
    assign o_data  = o_valid ? buf_q[rd_q] : '0;
    assign o_last  = o_valid && unloadLast;
    assign o_count = count_q;

endmodule
